audio_out_stage: RTL and testbench

AUDIO_OUT_STAGE -- requirements
Module: audio_out_stage

---
 rtl/audio_out_pkg.sv | 37 +++
 rtl/sample_rate_gen.sv | 35 +++
 rtl/audio_out_stage.sv | 146 ++++++++++++++
 tb/tb_audio_out_stage.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_out_pkg.sv
// Shared types and constants for the audio output stage.
// Holds the ramp FSM state enum, ramp/gain constants, PCM limits and the
// saturation helpers used by the gain stage and the optional DC blocker.
package audio_out_pkg;

  localparam int unsigned PCM_W      = 16;
  localparam int unsigned PROD_W     = 29;
  localparam int unsigned RAMP_W     = 9;
  localparam int unsigned GAIN_SHIFT = 11;

  localparam logic [RAMP_W-1:0]       RAMP_MAX = 9'd256;
  localparam logic signed [PCM_W-1:0] PCM_MAX  = 16'sh7FFF;
  localparam logic signed [PCM_W-1:0] PCM_MIN  = 16'sh8000;

  typedef enum logic [1:0] {
    RAMP_UP   = 2'd0,
    RUN       = 2'd1,
    RAMP_DOWN = 2'd2,
    MUTED     = 2'd3
  } ramp_state_e;

  // True when a wide value falls outside the 16-bit PCM range.
  function automatic logic is_sat(input logic signed [PROD_W-1:0] v);
    return (v > PROD_W'(PCM_MAX)) || (v < PROD_W'(PCM_MIN));
  endfunction

  // Clamp a wide value into the 16-bit PCM range.
  function automatic logic signed [PCM_W-1:0] sat_pcm(input logic signed [PROD_W-1:0] v);
    if (v > PROD_W'(PCM_MAX)) begin
      return PCM_MAX;
    end else if (v < PROD_W'(PCM_MIN)) begin
      return PCM_MIN;
    end
    return v[PCM_W-1:0];
  endfunction

endpackage

// File: rtl/sample_rate_gen.sv
// Drift-free fractional strobe generator (phase accumulator).
// Emits exactly SAMPLE_HZ one-cycle pulses per CLK_HZ clock cycles.
// Ports: clk (system clock), reset_n (async active-low), stb (registered pulse).
module sample_rate_gen #(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned SAMPLE_HZ = 48000
) (
  input  logic clk,
  input  logic reset_n,
  output logic stb
);

  // One spare bit so acc + SAMPLE_HZ (< 2*CLK_HZ) never wraps.
  localparam int unsigned ACC_W = $clog2(CLK_HZ) + 1;

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum_c;

  always_comb acc_sum_c = acc + ACC_W'(SAMPLE_HZ);

  // Pulse and fold the phase back whenever a full clock period is crossed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      stb <= 1'b0;
    end else if (acc_sum_c >= ACC_W'(CLK_HZ)) begin
      acc <= acc_sum_c - ACC_W'(CLK_HZ);
      stb <= 1'b1;
    end else begin
      acc <= acc_sum_c;
      stb <= 1'b0;
    end
  end

endmodule

// File: rtl/audio_out_stage.sv
// Audio output stage: sample-rate strobe, PCM capture, volume/fade gain with
// saturation, and a mute fade ramp FSM. Output latency is 2 cycles from strobe.
// Optional macro AUDIO_OUT_STAGE_DCBLOCK_EN inserts a DC blocker on the
// captured sample (same latency); undefined, the sample feeds the gain directly.
// Ports: clk, reset_n (async active-low), pcm_in (signed PCM), volume (0..15,
// 8 = unity), mute (fade request), audio_l/audio_r (signed, identical),
// sample_stb (rate pulse), clip (saturation pulse on update).
module audio_out_stage
  import audio_out_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 50000000,
  parameter int unsigned SAMPLE_HZ = 48000
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic signed [PCM_W-1:0] pcm_in,
  input  logic [3:0]              volume,
  input  logic                    mute,
  output logic signed [PCM_W-1:0] audio_l,
  output logic signed [PCM_W-1:0] audio_r,
  output logic                    sample_stb,
  output logic                    clip
);

  ramp_state_e              state, state_nxt_c;
  logic [RAMP_W-1:0]        ramp, ramp_nxt_c;
  logic [RAMP_W-1:0]        ramp_inc_c, ramp_dec_c;
  logic signed [PCM_W-1:0]  pcm_q;
  logic signed [PCM_W-1:0]  cap_val_c;
  logic                     cap_vld;
  logic signed [PROD_W-1:0] prod_c, gain_c;

  sample_rate_gen #(
    .CLK_HZ   (CLK_HZ),
    .SAMPLE_HZ(SAMPLE_HZ)
  ) u_rate (
    .clk    (clk),
    .reset_n(reset_n),
    .stb    (sample_stb)
  );

`ifdef AUDIO_OUT_STAGE_DCBLOCK_EN
  logic signed [PCM_W-1:0]  x_prev, y_prev;
  logic signed [PROD_W-1:0] dc_sum_c;

  // y = x - x_prev + y_prev - y_prev/256, evaluated on the incoming sample.
  always_comb begin
    dc_sum_c = PROD_W'(pcm_in) - PROD_W'(x_prev) + PROD_W'(y_prev)
             - PROD_W'(y_prev >>> 8);
    cap_val_c = sat_pcm(dc_sum_c);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x_prev <= '0;
      y_prev <= '0;
    end else if (sample_stb) begin
      x_prev <= pcm_in;
      y_prev <= cap_val_c;
    end
  end
`else
  always_comb cap_val_c = pcm_in;
`endif

  // Capture stage; the ramp steps together with the captured sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= RAMP_UP;
      ramp    <= '0;
      pcm_q   <= '0;
      cap_vld <= 1'b0;
    end else begin
      cap_vld <= sample_stb;
      if (sample_stb) begin
        state <= state_nxt_c;
        ramp  <= ramp_nxt_c;
        pcm_q <= cap_val_c;
      end
    end
  end

  // Ramp FSM: one step per strobe; mute picks the direction from the current value.
  always_comb begin
    state_nxt_c = state;
    ramp_nxt_c  = ramp;
    ramp_inc_c  = ramp + 9'd1;
    ramp_dec_c  = ramp - 9'd1;
    case (state)
      RAMP_UP, RAMP_DOWN: begin
        if (mute) begin
          // Reset leaves RAMP_UP at 0, so guard the decrement.
          if (ramp <= 9'd1) begin
            ramp_nxt_c  = '0;
            state_nxt_c = MUTED;
          end else begin
            ramp_nxt_c  = ramp_dec_c;
            state_nxt_c = RAMP_DOWN;
          end
        end else begin
          ramp_nxt_c  = ramp_inc_c;
          state_nxt_c = (ramp_inc_c == RAMP_MAX) ? RUN : RAMP_UP;
        end
      end
      RUN: begin
        if (mute) begin
          ramp_nxt_c  = RAMP_MAX - 9'd1;
          state_nxt_c = RAMP_DOWN;
        end
      end
      MUTED: begin
        if (!mute) begin
          ramp_nxt_c  = 9'd1;
          state_nxt_c = RAMP_UP;
        end
      end
      default: begin
        ramp_nxt_c  = '0;
        state_nxt_c = RAMP_UP;
      end
    endcase
  end

  // Gain stage: |pcm * volume * ramp| < 2^28, so 29 signed bits suffice.
  always_comb begin
    prod_c = PROD_W'(pcm_q) * $signed(PROD_W'(volume)) * $signed(PROD_W'(ramp));
    gain_c = prod_c >>> GAIN_SHIFT;
  end

  // Output register: update only the cycle after capture, clip pulses with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      audio_l <= '0;
      clip    <= 1'b0;
    end else begin
      clip <= 1'b0;
      if (cap_vld) begin
        audio_l <= sat_pcm(gain_c);
        clip    <= is_sat(gain_c);
      end
    end
  end

  assign audio_r = audio_l;

endmodule

// File: tb/tb_audio_out_stage.sv
module tb_audio_out_stage;
  import audio_out_pkg::*;

  localparam int unsigned TB_CLK_HZ    = 100;
  localparam int unsigned TB_SAMPLE_HZ = 7;

  logic               clk;
  logic               reset_n;
  logic signed [15:0] pcm_in;
  logic [3:0]         volume;
  logic               mute;
  logic signed [15:0] audio_l;
  logic signed [15:0] audio_r;
  logic               sample_stb;
  logic               clip;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int ramp_m;
  int xp_m;
  int yp_m;

  audio_out_stage #(
    .CLK_HZ   (TB_CLK_HZ),
    .SAMPLE_HZ(TB_SAMPLE_HZ)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pcm_in    (pcm_in),
    .volume    (volume),
    .mute      (mute),
    .audio_l   (audio_l),
    .audio_r   (audio_r),
    .sample_stb(sample_stb),
    .clip      (clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clamp16(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Behavioural model: one step per strobe, produces the expected output.
  task automatic model_strobe(input int p, input int v, input bit m,
                              output logic signed [15:0] exp_out, output bit exp_clip);
    int x;
    int prod;
    int g;
    if (m) ramp_m = (ramp_m > 0) ? ramp_m - 1 : 0;
    else   ramp_m = (ramp_m < 256) ? ramp_m + 1 : 256;
    x = p;
`ifdef AUDIO_OUT_STAGE_DCBLOCK_EN
    x = clamp16(p - xp_m + yp_m - (yp_m >>> 8));
    xp_m = p;
    yp_m = x;
`endif
    prod = x * v * ramp_m;
    g = prod >>> 11;
    exp_clip = (g > 32767) || (g < -32768);
    exp_out = 16'(clamp16(g));
  endtask

  task automatic model_reset();
    ramp_m = 0;
    xp_m = 0;
    yp_m = 0;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // Drive inputs, wait for a strobe, then check the update and the hold cycle.
  task automatic next_sample(input int p, input int v, input bit m);
    bit found;
    logic signed [15:0] exp_out;
    bit exp_clip;
    @(negedge clk);
    pcm_in = 16'(p);
    volume = 4'(v);
    mute   = m;
    found  = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (sample_stb === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL strobe_timeout: got no sample_stb in 40 cycles, required one");
      return;
    end
    model_strobe(p, v, m, exp_out, exp_clip);
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (audio_l !== exp_out) begin
      errors++;
      $display("FAIL audio_l: got %0d expected %0d (pcm=%0d vol=%0d ramp=%0d)",
               audio_l, exp_out, p, v, ramp_m);
    end
    checks++;
    if (audio_r !== exp_out) begin
      errors++;
      $display("FAIL audio_r: got %0d expected %0d", audio_r, exp_out);
    end
    checks++;
    if (clip !== exp_clip) begin
      errors++;
      $display("FAIL clip_update: got %0b expected %0b (pcm=%0d vol=%0d)", clip, exp_clip, p, v);
    end
    @(posedge clk);
    #1;
    checks++;
    if (clip !== 1'b0 || audio_l !== exp_out) begin
      errors++;
      $display("FAIL hold: got clip=%0b audio=%0d expected clip=0 audio=%0d", clip, audio_l, exp_out);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    pcm_in  = '0;
    volume  = 4'd8;
    mute    = 1'b0;
    #2 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (audio_l !== 16'sd0 || audio_r !== 16'sd0 || sample_stb !== 1'b0 || clip !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got l=%0d r=%0d stb=%0b clip=%0b expected all 0",
               audio_l, audio_r, sample_stb, clip);
    end
    checks++;
    if (dut.ramp !== 9'd0 || dut.state !== RAMP_UP) begin
      errors++;
      $display("FAIL reset_fsm: got ramp=%0d state=%0d expected ramp=0 state=RAMP_UP",
               dut.ramp, dut.state);
    end
    reset_n = 1'b1;
    model_reset();
  endtask

  // Pulse k must occur at the first cycle n with n*S >= k*C.
  task automatic test_strobe_rate();
    int pulses = 0;
    int bad = 0;
    int first = 0;
    bit exp_stb;
    reset_dut();
    for (int n = 1; n <= 3 * int'(TB_CLK_HZ); n++) begin
      @(posedge clk);
      #1;
      exp_stb = ((n * int'(TB_SAMPLE_HZ)) / int'(TB_CLK_HZ)) !=
                (((n - 1) * int'(TB_SAMPLE_HZ)) / int'(TB_CLK_HZ));
      checks++;
      if (sample_stb !== exp_stb) begin
        errors++;
        bad++;
        if (bad < 5)
          $display("FAIL stb_cycle: cycle %0d got %0b expected %0b", n, sample_stb, exp_stb);
      end
      if (sample_stb === 1'b1) begin
        pulses++;
        if (first == 0) first = n;
      end
    end
    checks++;
    if (pulses != 3 * int'(TB_SAMPLE_HZ)) begin
      errors++;
      $display("FAIL stb_count: got %0d expected %0d", pulses, 3 * TB_SAMPLE_HZ);
    end
    checks++;
    if (first != (int'(TB_CLK_HZ) + int'(TB_SAMPLE_HZ) - 1) / int'(TB_SAMPLE_HZ)) begin
      errors++;
      $display("FAIL stb_first: got cycle %0d expected %0d", first,
               (TB_CLK_HZ + TB_SAMPLE_HZ - 1) / TB_SAMPLE_HZ);
    end
  endtask

  task automatic test_ramp_up();
    reset_dut();
    for (int k = 1; k <= 260; k++) next_sample(16384, 8, 1'b0);
    checks++;
    if (audio_l !== 16'sd16384 || dut.state !== RUN) begin
      errors++;
      $display("FAIL ramp_up_end: got audio=%0d state=%0d expected 16384 RUN", audio_l, dut.state);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      next_sample(30000, 15, 1'b0);
      next_sample(-30000, 15, 1'b0);
    end
    next_sample(32767, 8, 1'b0);
    next_sample(-32768, 8, 1'b0);
    next_sample(17477, 15, 1'b0);
    next_sample(-32768, 0, 1'b0);
    next_sample(32767, 0, 1'b0);
  endtask

  task automatic test_mute();
    for (int i = 0; i < 100; i++) next_sample(16384, 8, 1'b1);
    checks++;
    if (dut.ramp !== 9'd156 || dut.state !== RAMP_DOWN) begin
      errors++;
      $display("FAIL mute_100: got ramp=%0d state=%0d expected 156 RAMP_DOWN", dut.ramp, dut.state);
    end
    for (int i = 0; i < 100; i++) next_sample(16384, 8, 1'b0);
    checks++;
    if (dut.ramp !== 9'd256 || dut.state !== RUN) begin
      errors++;
      $display("FAIL unmute_100: got ramp=%0d state=%0d expected 256 RUN", dut.ramp, dut.state);
    end
    for (int i = 0; i < 260; i++) next_sample(16384, 8, 1'b1);
    checks++;
    if (audio_l !== 16'sd0 || dut.state !== MUTED) begin
      errors++;
      $display("FAIL muted: got audio=%0d state=%0d expected 0 MUTED", audio_l, dut.state);
    end
  endtask

  task automatic test_random();
    logic signed [15:0] r16;
    bit m = 1'b0;
    for (int i = 0; i < 300; i++) begin
      r16 = 16'($urandom);
      if ($urandom_range(0, 39) == 0) m = ~m;
      next_sample(int'(r16), int'($urandom_range(0, 15)), m);
    end
  endtask

  // Reset asserted while a strobe is in flight, then restart from ramp 0.
  task automatic test_reset_mid();
    bit found = 1'b0;
    int n = 0;
    logic signed [15:0] exp_out;
    bit exp_clip;
    reset_dut();
    for (int k = 0; k < 128; k++) next_sample(16384, 8, 1'b0);
    @(negedge clk);
    for (int i = 0; i < 40 && !found; i++) begin
      if (sample_stb === 1'b1) found = 1'b1;
      else @(negedge clk);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (!found || audio_l !== 16'sd0 || audio_r !== 16'sd0 || sample_stb !== 1'b0 || clip !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: got l=%0d r=%0d stb=%0b clip=%0b found=%0b expected all 0",
               audio_l, audio_r, sample_stb, clip, found);
    end
    checks++;
    if (dut.ramp !== 9'd0 || dut.state !== RAMP_UP) begin
      errors++;
      $display("FAIL reset_mid_fsm: got ramp=%0d state=%0d expected 0 RAMP_UP", dut.ramp, dut.state);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    found = 1'b0;
    while (!found && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (sample_stb === 1'b1) found = 1'b1;
    end
    checks++;
    if (n != (int'(TB_CLK_HZ) + int'(TB_SAMPLE_HZ) - 1) / int'(TB_SAMPLE_HZ)) begin
      errors++;
      $display("FAIL restart_first_stb: got cycle %0d expected %0d", n,
               (TB_CLK_HZ + TB_SAMPLE_HZ - 1) / TB_SAMPLE_HZ);
    end
    model_strobe(16384, 8, 1'b0, exp_out, exp_clip);
    @(posedge clk);
    @(posedge clk);
    #1;
    checks++;
    if (audio_l !== exp_out || clip !== exp_clip) begin
      errors++;
      $display("FAIL restart_out: got %0d expected %0d", audio_l, exp_out);
    end
  endtask

  task automatic test_dc();
`ifdef AUDIO_OUT_STAGE_DCBLOCK_EN
    localparam int DC_STROBES = 1300;
`else
    localparam int DC_STROBES = 300;
`endif
    reset_dut();
    for (int i = 0; i < DC_STROBES; i++) next_sample(10000, 8, 1'b0);
    checks++;
`ifdef AUDIO_OUT_STAGE_DCBLOCK_EN
    if (!(audio_l < 16'sd100 && audio_l > -16'sd100)) begin
      errors++;
      $display("FAIL dc_decay: got %0d expected |out| < 100", audio_l);
    end
`else
    if (audio_l !== 16'sd10000) begin
      errors++;
      $display("FAIL dc_hold: got %0d expected 10000", audio_l);
    end
`endif
  endtask

  initial begin
    model_reset();
    test_reset();
    test_strobe_rate();
    test_ramp_up();
    test_saturation();
    test_mute();
    test_random();
    test_reset_mid();
    test_dc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
